vga_vtiming: RTL and testbench
==============================

VGA_VTIMING -- requirements
Module: vga_vtiming

Interface
REQ-001 Parameter H_TOTAL, 1600, clocks per line.
REQ-002 Parameter V_SYNC, 2, sync lines at frame start.
REQ-003 Parameter V_BACK, 29, back-porch lines after sync.
REQ-004 Parameter V_ACTIVE, 480, active lines.
REQ-005 Parameter V_FRONT, 10, front-porch lines; V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT.
REQ-006 Parameter V_DIV, 6, active lines per vaddr step (>=1).
REQ-007 Parameter ADDR_W, 7, vaddr width; ceil(V_ACTIVE/V_DIV) SHALL be <= 2^ADDR_W.
REQ-008 Parameter SYNC_POL, 0, vsync level during sync lines.
REQ-009 clk  input  1  single clock; all state on rising edge.
REQ-010 reset  input  1  asynchronous, active-low reset.
REQ-011 en  input  1  count enable; low freezes all counters and outputs.
REQ-012 restart  input  1  synchronous frame restart request.
REQ-013 vsync  output  1  vertical sync, SYNC_POL during sync lines, else ~SYNC_POL.
REQ-014 vactive  output  1  high during active lines.
REQ-015 vaddr  output  ADDR_W  row address, active line index divided by V_DIV.
REQ-016 line_tick  output  1  one-cycle pulse on last clock of each line.
REQ-017 frame_start  output  1  one-cycle pulse on first clock of each frame.

Function
REQ-018 hcnt SHALL count 0..H_TOTAL-1 while en=1, wrapping to 0; vcnt SHALL increment on hcnt wrap, wrapping 0 after V_TOTAL-1.
REQ-019 All outputs SHALL be registered and describe the current (hcnt,vcnt) in the same cycle (decoded from next-state).
REQ-020 vsync SHALL be SYNC_POL for vcnt < V_SYNC, else ~SYNC_POL.
REQ-021 vactive SHALL be 1 for V_SYNC+V_BACK <= vcnt < V_SYNC+V_BACK+V_ACTIVE.
REQ-022 vaddr SHALL be 0 from frame start, increment by 1 at hcnt=0 of every V_DIV-th active line after the first, hold last value through front porch, return to 0 at frame start.
REQ-023 line_tick SHALL be 1 exactly when hcnt = H_TOTAL-1 and en=1.
REQ-024 frame_start SHALL be 1 for one cycle each time (hcnt,vcnt) advances into (0,0), including via restart; not on reset release.
REQ-025 en=0: counters, vaddr, vsync, vactive hold; line_tick and frame_start forced 0.
REQ-026 restart=1 SHALL force hcnt=vcnt=0, vaddr=0 next cycle regardless of en; restart dominates en and wrap.
REQ-027 Counter widths SHALL be $clog2 of H_TOTAL and V_TOTAL; no counter SHALL exceed its terminal value.

Reset
REQ-028 reset low SHALL immediately clear hcnt, vcnt, vaddr, line_tick, frame_start, vactive to 0 and set vsync to SYNC_POL.
REQ-029 reset asserted mid-frame SHALL discard the frame; counting resumes from (0,0) on the first clk edge with reset high and en high.

Configuration
REQ-030 Macro VGA_VTIMING_FRAME_CNT_EN defined: extra output frame_cnt (16 bits, reset 0) increments on each frame_start, wrapping at 65535; undefined: port and counter absent, all other behaviour identical.

Structure
REQ-031 Package vga_timing_pkg SHALL hold default timing constants (H_TOTAL, V_SYNC, V_BACK, V_ACTIVE, V_FRONT, V_DIV) and a vtiming_phase_t enum (SYNC, BACK, ACTIVE, FRONT).
REQ-032 Sub-module vga_line_tick SHALL implement hcnt and line_tick; vga_vtiming instantiates it once.

Verification
REQ-033 Defaults, release reset, en=1 -> vsync=0 cycles 0..3199, 1 at cycle 3200; frame_start again at cycle 833600.
REQ-034 Defaults -> vactive first 1 at cycle 49600 with vaddr=0; vaddr=1 at cycle 59200; vaddr=79 at cycle 817600..833599; vaddr=0 at 833600.
REQ-035 H_TOTAL=4, V_SYNC=1, V_BACK=1, V_ACTIVE=4, V_FRONT=1, V_DIV=2 -> frame 28 cycles; vactive cycles 8..23; vaddr 0 at 8..15, 1 at 16..27.
REQ-036 en low for 10 cycles at cycle 100 -> all outputs frozen, no line_tick; sequence resumes shifted by 10 cycles.
REQ-037 restart at cycle 5000 with en=0 -> next cycle frame_start=1, vsync=0, vaddr=0; reset pulse at cycle 70000 -> outputs at reset values without waiting for clk.
REQ-038 With VGA_VTIMING_FRAME_CNT_EN -> frame_cnt=3 after three full default frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA vertical-timing defaults, the vertical phase type and a phase decoder.
package vga_timing_pkg;

  localparam int DEF_H_TOTAL  = 1600;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 29;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_DIV    = 6;

  typedef enum logic [1:0] {
    SYNC,
    BACK,
    ACTIVE,
    FRONT
  } vtiming_phase_t;

  // Maps a line number within the frame onto its vertical phase.
  function automatic vtiming_phase_t phase_of(input int line, input int v_sync,
                                              input int v_back, input int v_active);
    if (line < v_sync) return SYNC;
    else if (line < v_sync + v_back) return BACK;
    else if (line < v_sync + v_back + v_active) return ACTIVE;
    else return FRONT;
  endfunction

endpackage

// File: rtl/vga_line_tick.sv
// Horizontal clock counter: produces the line-wrap strobe and the registered line_tick.
module vga_line_tick
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic line_end,
  output logic line_tick
);

  localparam int H_W = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);

  logic [H_W-1:0] hcnt;
  logic [H_W-1:0] hcnt_next;

  always_comb begin
    hcnt_next = hcnt;
    if (restart) hcnt_next = '0;
    else if (en) hcnt_next = (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
  end

  // Asserted on the edge that moves the line counter off its last clock.
  assign line_end = en && !restart && (hcnt == H_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt      <= '0;
      line_tick <= 1'b0;
    end else begin
      hcnt      <= hcnt_next;
      line_tick <= en && !restart && (hcnt_next == H_LAST);
    end
  end

endmodule

// File: rtl/vga_vtiming.sv
// VGA vertical timing generator; outputs are registered from the next (hcnt,vcnt).
// Define VGA_VTIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_vtiming
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_DIV    = DEF_V_DIV,
  parameter int ADDR_W   = 7,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  output logic              vsync,
  output logic              vactive,
  output logic [ADDR_W-1:0] vaddr,
  output logic              line_tick,
  output logic              frame_start
`ifdef VGA_VTIMING_FRAME_CNT_EN
  , output logic [15:0]     frame_cnt
`endif
);

  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DIV_W   = (V_DIV > 1) ? $clog2(V_DIV) : 1;
  localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   ACT_FIRST = V_W'(V_SYNC + V_BACK);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(V_DIV - 1);

  logic                 line_end;
  logic [V_W-1:0]       vcnt, vcnt_next;
  logic [DIV_W-1:0]     dcnt, dcnt_next;
  logic [ADDR_W-1:0]    vaddr_next;
  logic                 frame_start_next;
  vtiming_phase_t       phase_next;

  vga_line_tick #(
    .H_TOTAL (H_TOTAL)
  ) u_line_tick (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .restart   (restart),
    .line_end  (line_end),
    .line_tick (line_tick)
  );

  always_comb begin
    vcnt_next = vcnt;
    if (restart) vcnt_next = '0;
    else if (line_end) vcnt_next = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
  end

  assign phase_next       = phase_of(int'(vcnt_next), V_SYNC, V_BACK, V_ACTIVE);
  assign frame_start_next = restart || (line_end && (vcnt == V_LAST));

  // dcnt counts active lines within the current vaddr row; vaddr holds through front porch.
  always_comb begin
    vaddr_next = vaddr;
    dcnt_next  = dcnt;
    if (restart || (line_end && (vcnt_next == '0 || vcnt_next == ACT_FIRST))) begin
      vaddr_next = '0;
      dcnt_next  = '0;
    end else if (line_end && phase_next == ACTIVE) begin
      if (dcnt == DIV_LAST) begin
        dcnt_next  = '0;
        vaddr_next = vaddr + 1'b1;
      end else begin
        dcnt_next = dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcnt        <= '0;
      dcnt        <= '0;
      vaddr       <= '0;
      vsync       <= SYNC_POL;
      vactive     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vcnt        <= vcnt_next;
      dcnt        <= dcnt_next;
      vaddr       <= vaddr_next;
      vsync       <= (phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
      vactive     <= (phase_next == ACTIVE);
      frame_start <= frame_start_next;
    end
  end

`ifdef VGA_VTIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_cnt <= '0;
    else if (frame_start_next) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_vtiming.sv
// Bench for vga_vtiming: two small configurations, a spec-derived vector table,
// hand sequences for freeze/restart/async reset, and randomized model checking.
module tb_vga_vtiming;

  logic clk = 1'b0;
  logic reset, en, restart;

  logic       a_vsync, a_vactive, a_lt, a_fs;
  logic [2:0] a_vaddr;
  logic       b_vsync, b_vactive, b_lt, b_fs;
  logic [1:0] b_vaddr;
`ifdef VGA_VTIMING_FRAME_CNT_EN
  logic [15:0] a_fcnt, b_fcnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_vtiming #(
    .H_TOTAL(4), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
    .V_DIV(2), .ADDR_W(3), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en), .restart(restart),
    .vsync(a_vsync), .vactive(a_vactive), .vaddr(a_vaddr),
    .line_tick(a_lt), .frame_start(a_fs)
`ifdef VGA_VTIMING_FRAME_CNT_EN
    , .frame_cnt(a_fcnt)
`endif
  );

  vga_vtiming #(
    .H_TOTAL(5), .V_SYNC(2), .V_BACK(3), .V_ACTIVE(7), .V_FRONT(2),
    .V_DIV(3), .ADDR_W(2), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en), .restart(restart),
    .vsync(b_vsync), .vactive(b_vactive), .vaddr(b_vaddr),
    .line_tick(b_lt), .frame_start(b_fs)
`ifdef VGA_VTIMING_FRAME_CNT_EN
    , .frame_cnt(b_fcnt)
`endif
  );

  // Reference model: linear position within the frame plus the two pulse flags.
  int cfg_h  [2] = '{4, 5};
  int cfg_vs [2] = '{1, 2};
  int cfg_vb [2] = '{1, 3};
  int cfg_va [2] = '{4, 7};
  int cfg_vf [2] = '{1, 2};
  int cfg_vd [2] = '{2, 3};
  bit cfg_pol[2] = '{1'b0, 1'b1};
  int mp  [2];
  bit mlt [2];
  bit mfs [2];
  int mfc [2];

  function automatic void model_step(input bit e, input bit r, input bit rst_low);
    for (int i = 0; i < 2; i++) begin
      int tot;
      tot = cfg_h[i] * (cfg_vs[i] + cfg_vb[i] + cfg_va[i] + cfg_vf[i]);
      if (rst_low) begin
        mp[i] = 0; mlt[i] = 0; mfs[i] = 0; mfc[i] = 0;
      end else if (r) begin
        mp[i] = 0; mlt[i] = 0; mfs[i] = 1;
      end else if (e) begin
        mp[i]  = (mp[i] + 1) % tot;
        mlt[i] = (mp[i] % cfg_h[i]) == cfg_h[i] - 1;
        mfs[i] = (mp[i] == 0);
      end else begin
        mlt[i] = 0; mfs[i] = 0;
      end
      if (!rst_low && mfs[i]) mfc[i] = (mfc[i] + 1) % 65536;
    end
  endfunction

  function automatic logic [11:0] exp_vec(input int i);
    int line, first, addr;
    logic vs, va;
    line  = mp[i] / cfg_h[i];
    first = cfg_vs[i] + cfg_vb[i];
    vs    = (line < cfg_vs[i]) ? cfg_pol[i] : ~cfg_pol[i];
    va    = (line >= first) && (line < first + cfg_va[i]);
    if (va) addr = (line - first) / cfg_vd[i];
    else if (line >= first + cfg_va[i]) addr = (cfg_va[i] + cfg_vd[i] - 1) / cfg_vd[i] - 1;
    else addr = 0;
    return {vs, va, 8'(addr), mlt[i], mfs[i]};
  endfunction

  function automatic logic [11:0] dut_vec(input int i);
    if (i == 0) return {a_vsync, a_vactive, 8'(a_vaddr), a_lt, a_fs};
    else        return {b_vsync, b_vactive, 8'(b_vaddr), b_lt, b_fs};
  endfunction

  function automatic logic [11:0] mk(input logic vs, input logic va, input int addr,
                                     input logic lt, input logic fs);
    return {vs, va, 8'(addr), lt, fs};
  endfunction

  task automatic cmp(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (vsync,vactive,vaddr[8],line_tick,frame_start)",
               name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("%s_model_inst%0d", tag, i), dut_vec(i), exp_vec(i));
`ifdef VGA_VTIMING_FRAME_CNT_EN
      cmp($sformatf("%s_fcnt_inst%0d", tag, i),
          12'((i == 0) ? a_fcnt : b_fcnt), 12'(mfc[i]));
`endif
    end
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input bit e, input bit r);
    en = e; restart = r;
    @(posedge clk);
    model_step(e, r, !reset);
    @(negedge clk);
  endtask

  typedef struct {
    int          cyc;
    logic [11:0] vec;
  } tv_t;
  tv_t tv[12];

  initial begin
    int cyc;
    reset = 1'b0; en = 1'b0; restart = 1'b0;
    model_step(0, 0, 1);

    tv[0]  = '{0,  mk(0, 0, 0, 0, 0)};
    tv[1]  = '{3,  mk(0, 0, 0, 1, 0)};
    tv[2]  = '{4,  mk(1, 0, 0, 0, 0)};
    tv[3]  = '{7,  mk(1, 0, 0, 1, 0)};
    tv[4]  = '{8,  mk(1, 1, 0, 0, 0)};
    tv[5]  = '{15, mk(1, 1, 0, 1, 0)};
    tv[6]  = '{16, mk(1, 1, 1, 0, 0)};
    tv[7]  = '{23, mk(1, 1, 1, 1, 0)};
    tv[8]  = '{24, mk(1, 0, 1, 0, 0)};
    tv[9]  = '{27, mk(1, 0, 1, 1, 0)};
    tv[10] = '{28, mk(0, 0, 0, 0, 1)};
    tv[11] = '{29, mk(0, 0, 0, 0, 0)};

    repeat (2) @(negedge clk);
    cmp("reset_state_a", dut_vec(0), mk(0, 0, 0, 0, 0));
    cmp("reset_state_b", dut_vec(1), mk(1, 0, 0, 0, 0));
    reset = 1'b1;

    // Spec-derived frame of the small configuration
    cyc = 0;
    for (int k = 0; k < 12; k++) begin
      while (cyc < tv[k].cyc) begin
        step(1, 0);
        cyc++;
        check_all("table_run");
      end
      cmp($sformatf("table_cyc%0d", tv[k].cyc), dut_vec(0), tv[k].vec);
    end

    // Freeze on a line_tick cycle: no pulses while en is low, then resume
    while ((cyc % 28) != 3) begin step(1, 0); cyc++; end
    for (int k = 0; k < 10; k++) begin
      step(0, 0);
      cmp("freeze_pulses_a", {10'd0, a_lt, a_fs}, 12'd0);
      check_all("freeze");
    end
    repeat (6) begin step(1, 0); check_all("resume"); end

    // Restart while disabled from inside the active region
    repeat (14) step(1, 0);
    check_all("pre_restart");
    step(0, 1);
    cmp("restart_en0_a", dut_vec(0), mk(0, 0, 0, 0, 1));
    cmp("restart_en0_b", dut_vec(1), mk(1, 0, 0, 0, 1));
    step(0, 0);
    check_all("post_restart");

    // Asynchronous reset mid-frame, observed before any clock edge
    repeat (18) step(1, 0);
    check_all("pre_reset");
    #2 reset = 1'b0;
    #1;
    model_step(0, 0, 1);
    cmp("async_reset_a", dut_vec(0), mk(0, 0, 0, 0, 0));
    cmp("async_reset_b", dut_vec(1), mk(1, 0, 0, 0, 0));
    @(negedge clk);
    step(1, 0);
    reset = 1'b1;
    check_all("held_reset");
    step(1, 0);
    cmp("resume_after_reset_a", dut_vec(0), mk(0, 0, 0, 0, 0));
    check_all("after_reset");

    // Randomized enable/restart/reset traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bit e, r;
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if (!reset) model_step(0, 0, 1);
      step(e, r);
      check_all("random");
    end
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
